rs_issue_scheduler: RTL and testbench

- Schedules a bank of NUM_RS reservation stations that share one functional unit (ALU or AGU).
- Allocation side: picks a free station for each instruction from dispatch and drives that station's enable.
- Issue side: picks one ready station in round-robin order, holds a registered valid/ready handshake to the FU, and pulses the station's dispatched input when the FU accepts.
- Sits between decode/rename, the RS bank, and the FU operand mux.

---
 rtl/rs_issue_scheduler.sv | 146 ++++++++++++++
 tb/tb_rs_issue_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler
// Allocation and issue scheduler for a bank of reservation stations that
// share one functional unit. Allocation picks the lowest free station for
// the instruction arriving from dispatch. Issue picks one ready station in
// round-robin order, presents it to the FU through a registered valid/index
// pair, and pulses that station's dispatched input when the FU accepts it.

module rs_issue_scheduler #(
   parameter int NUM_RS    = 4,
   parameter int TAG_WIDTH = 5,
   parameter int IDX_WIDTH = $clog2(NUM_RS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        alloc_request,
   input  logic [NUM_RS-1:0]           rs_busy,
   input  logic [NUM_RS-1:0]           rs_ready,
   input  logic [NUM_RS*TAG_WIDTH-1:0] rs_rob_tag,
   input  logic                        fu_ready,
   output logic [NUM_RS-1:0]           alloc_enable,
   output logic                        alloc_stall,
   output logic                        issue_valid,
   output logic [IDX_WIDTH-1:0]        issue_index,
   output logic [TAG_WIDTH-1:0]        issue_rob_tag,
   output logic [NUM_RS-1:0]           dispatch_ack
);

   // Issue FSM: IDLE has nothing in front of the FU, HOLD presents one op.
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] HOLD = 1'b1;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_RS - 1);

   logic [0:0]           state_q, state_d;
   logic [IDX_WIDTH-1:0] issue_index_q, issue_index_d;
   logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

   logic [NUM_RS-1:0]    freeMask;
   logic [NUM_RS-1:0]    allocOnehot;
   logic                 allocFound;
   logic [NUM_RS-1:0]    issueOnehot;
   logic [NUM_RS-1:0]    candMask;
   logic                 selectedBusy;
   logic                 accept;
   logic                 cancel;
   logic                 pickFound;
   logic [IDX_WIDTH-1:0] pickIdx;
   int                   scanPos;

   assign freeMask = ~rs_busy;

   // Lowest-index free station; a station's busy flag sets on the same edge
   // as its enable, so no extra masking of a just-allocated station is needed.
   always_comb begin
      allocOnehot = '0;
      allocFound  = 1'b0;
      for (int i = 0; i < NUM_RS; i++) begin
         if (!allocFound && freeMask[i]) begin
            allocOnehot[i] = 1'b1;
            allocFound     = 1'b1;
         end
      end
   end

   assign alloc_enable = alloc_request ? allocOnehot : '0;
   assign alloc_stall  = alloc_request && (freeMask == '0);

   assign issue_valid  = (state_q == HOLD);
   assign issue_index  = issue_index_q;
   assign issueOnehot  = NUM_RS'(1) << issue_index_q;
   assign selectedBusy = rs_busy[issue_index_q];

   // The FU only takes the op while the station still owns it; a station that
   // was flushed under us cancels the handshake instead of being acked.
   assign accept       = issue_valid && fu_ready && selectedBusy;
   assign cancel       = issue_valid && !selectedBusy;
   assign dispatch_ack = accept ? issueOnehot : '0;

   assign issue_rob_tag = rs_rob_tag[issue_index_q*TAG_WIDTH +: TAG_WIDTH];

   // The station already held by the FU is not a candidate for the next pick.
   assign candMask = rs_ready & ~(issue_valid ? issueOnehot : '0);

   // Round-robin pick: first candidate scanning from rr_ptr upward, wrapping.
   always_comb begin
      pickFound = 1'b0;
      pickIdx   = '0;
      scanPos   = 0;
      for (int k = 0; k < NUM_RS; k++) begin
         scanPos = int'(rr_ptr_q) + k;
         if (scanPos >= NUM_RS) begin
            scanPos = scanPos - NUM_RS;
         end
         if (!pickFound && candMask[scanPos[IDX_WIDTH-1:0]]) begin
            pickFound = 1'b1;
            pickIdx   = scanPos[IDX_WIDTH-1:0];
         end
      end
   end

   // Next-state logic: load in IDLE, hold steady in HOLD until accept or cancel.
   always_comb begin
      state_d       = state_q;
      issue_index_d = issue_index_q;
      rr_ptr_d      = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (pickFound) begin
               state_d       = HOLD;
               issue_index_d = pickIdx;
            end
         end
         HOLD: begin
            if (accept || cancel) begin
               if (accept) begin
                  rr_ptr_d = (issue_index_q == LAST_IDX) ? '0
                                                         : issue_index_q + IDX_WIDTH'(1);
               end
               if (pickFound) begin
                  state_d       = HOLD;
                  issue_index_d = pickIdx;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         issue_index_q <= '0;
         rr_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         issue_index_q <= issue_index_d;
         rr_ptr_q      <= rr_ptr_d;
      end
   end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler
// Table-driven bench for rs_issue_scheduler with NUM_RS=4. Each record holds
// one cycle of inputs and the outputs expected in that cycle; expectations are
// queued when the inputs are driven and popped when the outputs are sampled.

module tb_rs_issue_scheduler;

   localparam int NUM_RS    = 4;
   localparam int TAG_WIDTH = 5;
   localparam int IDX_WIDTH = 2;

   logic                        clk;
   logic                        reset;
   logic                        alloc_request;
   logic [NUM_RS-1:0]           rs_busy;
   logic [NUM_RS-1:0]           rs_ready;
   logic [NUM_RS*TAG_WIDTH-1:0] rs_rob_tag;
   logic                        fu_ready;
   logic [NUM_RS-1:0]           alloc_enable;
   logic                        alloc_stall;
   logic                        issue_valid;
   logic [IDX_WIDTH-1:0]        issue_index;
   logic [TAG_WIDTH-1:0]        issue_rob_tag;
   logic [NUM_RS-1:0]           dispatch_ack;

   rs_issue_scheduler #(
      .NUM_RS    (NUM_RS),
      .TAG_WIDTH (TAG_WIDTH),
      .IDX_WIDTH (IDX_WIDTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .alloc_request (alloc_request),
      .rs_busy       (rs_busy),
      .rs_ready      (rs_ready),
      .rs_rob_tag    (rs_rob_tag),
      .fu_ready      (fu_ready),
      .alloc_enable  (alloc_enable),
      .alloc_stall   (alloc_stall),
      .issue_valid   (issue_valid),
      .issue_index   (issue_index),
      .issue_rob_tag (issue_rob_tag),
      .dispatch_ack  (dispatch_ack)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string      name;
      logic       rstN;
      logic       areq;
      logic [3:0] busy;
      logic [3:0] ready;
      logic       fu;
      logic [3:0] expEn;
      logic       expStall;
      logic       expValid;
      logic       chkIdx;
      logic [1:0] expIdx;
      logic [3:0] expAck;
   } vec_t;

   vec_t vecs[$];
   vec_t tail[$];
   vec_t expQ[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic vec_t mk(input string nm, input logic r, input logic a,
                               input logic [3:0] b, input logic [3:0] rd, input logic f,
                               input logic [3:0] en, input logic st, input logic v,
                               input logic ci, input logic [1:0] ix, input logic [3:0] ak);
      vec_t t;
      t.name = nm;  t.rstN = r;     t.areq = a;     t.busy = b;
      t.ready = rd; t.fu = f;       t.expEn = en;   t.expStall = st;
      t.expValid = v; t.chkIdx = ci; t.expIdx = ix; t.expAck = ak;
      return t;
   endfunction

   // Station i carries ROB tag 7*i+3.
   function automatic logic [TAG_WIDTH-1:0] tagOf(input logic [1:0] idx);
      return TAG_WIDTH'(int'(idx) * 7 + 3);
   endfunction

   task automatic checkField(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      reset         = v.rstN;
      alloc_request = v.areq;
      rs_busy       = v.busy;
      rs_ready      = v.ready;
      fu_ready      = v.fu;
      expQ.push_back(v);
   endtask

   task automatic checkOutput();
      vec_t e;
      if (expQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL scoreboard actual=empty required=entry");
         return;
      end
      e = expQ.pop_front();
      checkField({e.name, ".alloc_enable"}, 32'(alloc_enable), 32'(e.expEn));
      checkField({e.name, ".alloc_stall"},  32'(alloc_stall),  32'(e.expStall));
      checkField({e.name, ".issue_valid"},  32'(issue_valid),  32'(e.expValid));
      checkField({e.name, ".dispatch_ack"}, 32'(dispatch_ack), 32'(e.expAck));
      if (e.chkIdx) begin
         checkField({e.name, ".issue_index"}, 32'(issue_index), 32'(e.expIdx));
      end
      if (e.expValid) begin
         checkField({e.name, ".issue_rob_tag"}, 32'(issue_rob_tag), 32'(tagOf(e.expIdx)));
      end
   endtask

   task automatic runList(input vec_t lst[$]);
      for (int i = 0; i < lst.size(); i++) begin
         applyStimulus(lst[i]);
         @(negedge clk);
         checkOutput();
         @(posedge clk);
         #1;
      end
   endtask

   // Hard stop in case the run wanders off.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset, table vectors, then the reset-mid-handshake case.
   initial begin
      int waited;
      reset         = 1'b0;
      alloc_request = 1'b0;
      rs_busy       = '0;
      rs_ready      = '0;
      fu_ready      = 1'b0;
      rs_rob_tag    = {5'd24, 5'd17, 5'd10, 5'd3};
      repeat (2) @(posedge clk);
      #1;

      // name, rstN, areq, busy, ready, fu | en, stall, valid, chkIdx, idx, ack
      vecs.push_back(mk("rst",      0, 0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 4'b0000));
      vecs.push_back(mk("alloc0",   1, 1, 4'b0000, 4'b0000, 0, 4'b0001, 0, 0, 1, 0, 4'b0000));
      vecs.push_back(mk("alloc1",   1, 1, 4'b0001, 4'b0000, 0, 4'b0010, 0, 0, 1, 0, 4'b0000));
      vecs.push_back(mk("alloc2",   1, 1, 4'b0011, 4'b0000, 0, 4'b0100, 0, 0, 1, 0, 4'b0000));
      vecs.push_back(mk("alloc3",   1, 1, 4'b0111, 4'b0000, 0, 4'b1000, 0, 0, 1, 0, 4'b0000));
      vecs.push_back(mk("allocFull",1, 1, 4'b1111, 4'b0000, 0, 4'b0000, 1, 0, 1, 0, 4'b0000));
      vecs.push_back(mk("noReq",    1, 0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 1, 0, 4'b0000));
      vecs.push_back(mk("b2b0",     1, 0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 1, 0, 4'b0000));
      vecs.push_back(mk("b2b1",     1, 0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 1, 1, 0, 4'b0001));
      vecs.push_back(mk("b2b2",     1, 0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 1, 1, 1, 4'b0010));
      vecs.push_back(mk("b2b3",     1, 0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 1, 1, 2, 4'b0100));
      vecs.push_back(mk("b2b4",     1, 0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 1, 1, 3, 4'b1000));
      vecs.push_back(mk("b2bWrap",  1, 0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 1, 1, 0, 4'b0000));
      vecs.push_back(mk("b2bDrain", 1, 0, 4'b1111, 4'b0000, 1, 4'b0000, 0, 1, 1, 0, 4'b0001));
      vecs.push_back(mk("b2bIdle",  1, 0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));
      vecs.push_back(mk("hold0",    1, 0, 4'b1111, 4'b0100, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));
      vecs.push_back(mk("hold1",    1, 0, 4'b1111, 4'b0100, 0, 4'b0000, 0, 1, 1, 2, 4'b0000));
      vecs.push_back(mk("hold2",    1, 0, 4'b1111, 4'b0100, 0, 4'b0000, 0, 1, 1, 2, 4'b0000));
      vecs.push_back(mk("hold3",    1, 0, 4'b1111, 4'b0100, 0, 4'b0000, 0, 1, 1, 2, 4'b0000));
      vecs.push_back(mk("holdAck",  1, 0, 4'b1111, 4'b0100, 1, 4'b0000, 0, 1, 1, 2, 4'b0100));
      vecs.push_back(mk("holdIdle", 1, 0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));
      vecs.push_back(mk("flush0",   1, 0, 4'b1111, 4'b0010, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));
      vecs.push_back(mk("flush1",   1, 0, 4'b1111, 4'b0010, 0, 4'b0000, 0, 1, 1, 1, 4'b0000));
      vecs.push_back(mk("flush2",   1, 0, 4'b1101, 4'b0000, 0, 4'b0000, 0, 1, 1, 1, 4'b0000));
      vecs.push_back(mk("flush3",   1, 0, 4'b1101, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 4'b0000));
      vecs.push_back(mk("rr0",      1, 0, 4'b1111, 4'b0010, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));
      vecs.push_back(mk("rr1",      1, 0, 4'b1111, 4'b0000, 1, 4'b0000, 0, 1, 1, 1, 4'b0010));
      vecs.push_back(mk("rr2",      1, 1, 4'b1111, 4'b1001, 0, 4'b0000, 1, 0, 0, 0, 4'b0000));
      vecs.push_back(mk("rr3",      1, 1, 4'b1011, 4'b1001, 1, 4'b0100, 0, 1, 1, 3, 4'b1000));
      vecs.push_back(mk("rr4",      1, 0, 4'b1111, 4'b0000, 1, 4'b0000, 0, 1, 1, 0, 4'b0001));
      vecs.push_back(mk("rr5",      1, 0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));
      vecs.push_back(mk("gate0",    1, 0, 4'b1111, 4'b0001, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));
      vecs.push_back(mk("gate1",    1, 0, 4'b1110, 4'b0000, 1, 4'b0000, 0, 1, 1, 0, 4'b0000));
      vecs.push_back(mk("gate2",    1, 0, 4'b1110, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 4'b0000));

      runList(vecs);

      // Station 2 becomes ready; wait a bounded number of cycles for the issue.
      reset         = 1'b1;
      alloc_request = 1'b0;
      rs_busy       = 4'b1111;
      rs_ready      = 4'b0100;
      fu_ready      = 1'b0;
      waited        = 0;
      @(negedge clk);
      while (issue_valid !== 1'b1 && waited < 8) begin
         @(posedge clk);
         #1;
         waited++;
         @(negedge clk);
      end
      checkField("midRst.latency", 32'(waited), 32'd1);
      checkField("midRst.valid", 32'(issue_valid), 32'd1);
      checkField("midRst.index", 32'(issue_index), 32'd2);
      @(posedge clk);
      #1;

      // Reset lands mid-handshake; afterwards rr_ptr is back at 0 so station 0
      // wins over station 3.
      tail.push_back(mk("midRst0", 0, 0, 4'b1111, 4'b0100, 0, 4'b0000, 0, 1, 1, 2, 4'b0000));
      tail.push_back(mk("midRst1", 1, 0, 4'b1111, 4'b1001, 0, 4'b0000, 0, 0, 1, 0, 4'b0000));
      tail.push_back(mk("midRst2", 1, 0, 4'b1111, 4'b1001, 1, 4'b0000, 0, 1, 1, 0, 4'b0001));
      tail.push_back(mk("midRst3", 1, 0, 4'b1111, 4'b1000, 0, 4'b0000, 0, 1, 1, 3, 4'b0000));
      runList(tail);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
